// File: rtl/bbox_scan_engine.sv
// Raster-scans an IMG_W x IMG_H image from a synchronous-read pixel RAM and reports the
// bounding box and pixel count of everything classified as foreground.
module bbox_scan_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int RD_LAT = 1,
    localparam int X_W    = $clog2(IMG_W),
    localparam int Y_W    = $clog2(IMG_H),
    localparam int ADDR_W = $clog2(IMG_W * IMG_H),
    localparam int CNT_W  = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  threshold,
    input  logic              polarity,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [X_W-1:0]    x_min,
    output logic [Y_W-1:0]    y_min,
    output logic [X_W-1:0]    x_max,
    output logic [Y_W-1:0]    y_max,
    output logic [CNT_W-1:0]  fg_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(IMG_H - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

    function automatic logic is_fg(input logic [PIX_W-1:0] pix,
                                   input logic [PIX_W-1:0] thr,
                                   input logic             pol);
        if (pol) begin
            return (pix >= thr);
        end else begin
            return (pix < thr);
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic [1:0]         drain_cnt_r;
    logic [PIX_W-1:0]   thr_r;
    logic               pol_r;
    logic [RD_LAT-1:0]  tag_v_r;
    logic [X_W-1:0]     tag_x_r [RD_LAT];
    logic [Y_W-1:0]     tag_y_r [RD_LAT];
    logic [X_W-1:0]     rmin_x_r, rmax_x_r;
    logic [Y_W-1:0]     rmin_y_r, rmax_y_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               any_r;
    logic               busy_r, done_r, found_r;
    logic [X_W-1:0]     x_min_r, x_max_r;
    logic [Y_W-1:0]     y_min_r, y_max_r;
    logic [CNT_W-1:0]   fg_count_r;

    logic               start_ok_s, abort_ok_s, finish_s;
    logic               pix_v_s, pix_fg_s;
    logic [X_W-1:0]     pix_x_s;
    logic [Y_W-1:0]     pix_y_s;

    // abort outranks a simultaneous start, so the pair never launches a scan
    assign start_ok_s = start && !abort && (state_r == S_IDLE || state_r == S_DONE);
    assign abort_ok_s = abort && (state_r == S_SCAN || state_r == S_DRAIN);
    assign finish_s   = (state_r == S_DRAIN) && (state_nxt_s == S_DONE);

    assign pix_v_s  = tag_v_r[RD_LAT-1];
    assign pix_x_s  = tag_x_r[RD_LAT-1];
    assign pix_y_s  = tag_y_r[RD_LAT-1];
    assign pix_fg_s = is_fg(rd_data, thr_r, pol_r);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_nxt_s = S_SCAN;
                else            state_nxt_s = S_IDLE;
            end
            S_SCAN: begin
                if (abort_ok_s)               state_nxt_s = S_IDLE;
                else if (addr_r == LAST_ADDR) state_nxt_s = S_DRAIN;
                else                          state_nxt_s = S_SCAN;
            end
            // DRAIN spans RD_LAT+1 cycles: the final pixel lands in the running
            // registers one edge before they are copied to the outputs
            S_DRAIN: begin
                if (abort_ok_s)                      state_nxt_s = S_IDLE;
                else if (drain_cnt_r == DRAIN_LAST)  state_nxt_s = S_DONE;
                else                                 state_nxt_s = S_DRAIN;
            end
            S_DONE: begin
                if (start_ok_s) state_nxt_s = S_SCAN;
                else            state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state_r <= S_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Raster address generator and drain counter
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            addr_r      <= '0;
            x_r         <= '0;
            y_r         <= '0;
            drain_cnt_r <= 2'd0;
        end else begin
            if (start_ok_s) begin
                addr_r <= '0;
                x_r    <= '0;
                y_r    <= '0;
            end else if (state_r == S_SCAN && state_nxt_s == S_SCAN) begin
                addr_r <= addr_r + ADDR_W'(1);
                if (x_r == X_LAST) begin
                    x_r <= '0;
                    y_r <= (y_r == Y_LAST) ? '0 : y_r + Y_W'(1);
                end else begin
                    x_r <= x_r + X_W'(1);
                end
            end
            if (state_r == S_DRAIN) drain_cnt_r <= drain_cnt_r + 2'd1;
            else                    drain_cnt_r <= 2'd0;
        end
    end

    // Coordinate tag pipe matching the RAM read latency
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            tag_v_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_x_r[i] <= '0;
                tag_y_r[i] <= '0;
            end
        end else if (abort_ok_s) begin
            tag_v_r <= '0;
        end else begin
            tag_v_r[0] <= (state_r == S_SCAN);
            tag_x_r[0] <= x_r;
            tag_y_r[0] <= y_r;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_x_r[i] <= tag_x_r[i-1];
                tag_y_r[i] <= tag_y_r[i-1];
            end
        end
    end

    // Scan configuration and running bounding-box accumulators
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            thr_r    <= '0;
            pol_r    <= 1'b0;
            rmin_x_r <= X_LAST;
            rmin_y_r <= Y_LAST;
            rmax_x_r <= '0;
            rmax_y_r <= '0;
            cnt_r    <= '0;
            any_r    <= 1'b0;
        end else if (start_ok_s) begin
            thr_r    <= threshold;
            pol_r    <= polarity;
            rmin_x_r <= X_LAST;
            rmin_y_r <= Y_LAST;
            rmax_x_r <= '0;
            rmax_y_r <= '0;
            cnt_r    <= '0;
            any_r    <= 1'b0;
        end else if (pix_v_s && pix_fg_s) begin
            if (pix_x_s < rmin_x_r) rmin_x_r <= pix_x_s;
            if (pix_y_s < rmin_y_r) rmin_y_r <= pix_y_s;
            if (pix_x_s > rmax_x_r) rmax_x_r <= pix_x_s;
            if (pix_y_s > rmax_y_r) rmax_y_r <= pix_y_s;
            cnt_r <= cnt_r + CNT_W'(1);
            any_r <= 1'b1;
        end
    end

    // Status flags and result registers
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            found_r    <= 1'b0;
            x_min_r    <= '0;
            y_min_r    <= '0;
            x_max_r    <= '0;
            y_max_r    <= '0;
            fg_count_r <= '0;
        end else begin
            busy_r <= (state_nxt_s == S_SCAN) || (state_nxt_s == S_DRAIN);
            done_r <= (state_nxt_s == S_DONE);
            if (finish_s) begin
                found_r    <= any_r;
                x_min_r    <= any_r ? rmin_x_r : '0;
                y_min_r    <= any_r ? rmin_y_r : '0;
                x_max_r    <= any_r ? rmax_x_r : '0;
                y_max_r    <= any_r ? rmax_y_r : '0;
                fg_count_r <= any_r ? cnt_r    : '0;
            end
        end
    end

    assign rd_addr  = addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign found    = found_r;
    assign x_min    = x_min_r;
    assign y_min    = y_min_r;
    assign x_max    = x_max_r;
    assign y_max    = y_max_r;
    assign fg_count = fg_count_r;

endmodule
